// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared mode/state types and seed constants for the recurrence generator
// Ports: none (package). Optional build macro SEQ_GEN_SAT_EN is consumed by seq_gen and seq_gen_add.
package seq_gen_pkg;
    typedef enum logic [1:0] {MODE_FIB = 2'b00, MODE_LUC = 2'b01, MODE_CUST = 2'b10} mode_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
    localparam int FIB_A = 0;
    localparam int FIB_B = 1;
    localparam int LUC_A = 2;
    localparam int LUC_B = 1;
endpackage

// File: rtl/seq_gen_add.sv
// seq_gen_add: W-bit adder with carry-out, saturating to all-ones when SEQ_GEN_SAT_EN is defined
// Ports: i_a, i_b  addends; o_sum  W-bit sum (wrapped, or saturated under SEQ_GEN_SAT_EN);
//        o_cout  carry out of the full W+1-bit sum.
module seq_gen_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);
    logic [W:0] w_full;
    assign w_full = {1'b0, i_a} + {1'b0, i_b};
    assign o_cout = w_full[W];
`ifdef SEQ_GEN_SAT_EN
    assign o_sum = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
`else
    assign o_sum = w_full[W-1:0];
`endif
endmodule

// File: rtl/seq_gen.sv
// seq_gen: run-length-limited integer recurrence generator (term k = term k-1 + term k-2) with valid/ready output
// Ports: clk, rst (sync, active-high); start, mode, seed_a, seed_b, n_terms sampled in IDLE;
//        stop aborts a run; out_ready accepts the current term;
//        out_valid/out_data/out_idx stream; busy in RUN; done one-cycle end pulse; ovf sticky overflow flag.
// Build macro SEQ_GEN_SAT_EN: overflow saturates terms to all-ones instead of ending the run.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int W  = 16,
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  seed_a,
    input  logic [W-1:0]  seed_b,
    input  logic [NW-1:0] n_terms,
    input  logic          stop,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic [NW-1:0] out_idx,
    output logic          busy,
    output logic          done,
    output logic          ovf
);
    state_e        r_state, w_next;
    logic [W-1:0]  r_cur, r_prv, w_sum, w_seed_a, w_seed_b;
    logic [NW-1:0] r_idx, r_n;
    logic          r_ovf, w_cout, w_acc, w_last, w_carry, w_end, w_adv;

    seq_gen_add #(.W(W)) u_add (.i_a(r_cur), .i_b(r_prv), .o_sum(w_sum), .o_cout(w_cout));

    // reserved mode 11 falls through to the Fibonacci seeds
    assign w_seed_a = (mode == MODE_CUST) ? seed_a : (mode == MODE_LUC) ? W'(LUC_A) : W'(FIB_A);
    assign w_seed_b = (mode == MODE_CUST) ? seed_b : (mode == MODE_LUC) ? W'(LUC_B) : W'(FIB_B);

    assign w_acc  = (r_state == S_RUN) && out_ready;
    assign w_last = r_idx == r_n - NW'(1);
    // term 0 -> 1 just moves the second seed, so only later sums can carry;
    // on the last term no successor is built, so the count limit masks overflow
    assign w_carry = w_acc && !w_last && (r_idx != '0) && w_cout;
`ifdef SEQ_GEN_SAT_EN
    assign w_end = w_acc && w_last;
`else
    assign w_end = w_acc && (w_last || w_carry);
`endif
    assign w_adv = w_acc && !stop && !w_end;

    always_comb begin
        w_next    = (r_state == S_IDLE) ? (start ? ((n_terms == '0) ? S_DONE : S_RUN) : S_IDLE)
                  : (r_state == S_RUN)  ? ((stop || w_end) ? S_DONE : S_RUN)
                  : S_IDLE;
        out_valid = r_state == S_RUN;
        busy      = r_state == S_RUN;
        done      = r_state == S_DONE;
        out_data  = r_cur;
        out_idx   = r_idx;
        ovf       = r_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_prv   <= '0;
            r_idx   <= '0;
            r_n     <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_ovf <= 1'b0;
                r_n   <= n_terms;
                if (n_terms != '0) begin
                    r_cur <= w_seed_a;
                    r_prv <= w_seed_b;
                    r_idx <= '0;
                end
            end
            if (w_carry && !stop)
                r_ovf <= 1'b1;
            // r_prv holds the second seed until term 0 is accepted, so that step is a swap
            if (w_adv) begin
                r_cur <= (r_idx == '0) ? r_prv : w_sum;
                r_prv <= r_cur;
                r_idx <= r_idx + NW'(1);
            end
        end
    end
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: table-driven scoreboard bench for seq_gen
module tb_seq_gen;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, out_ready = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] seed_a = 16'd0, seed_b = 16'd0;
    logic [7:0]  n_terms = 8'd0;
    logic        out_valid, busy, done, ovf;
    logic [15:0] out_data;
    logic [7:0]  out_idx;
    int checks = 0, failures = 0;

    typedef struct {logic [15:0] d; logic [7:0] i;} term_t;
    typedef struct {logic [1:0] m; logic [15:0] a; logic [15:0] b; logic [7:0] n;
                    logic [15:0] last; logic [7:0] idx; logic ovf;} vec_t;
    term_t q[$];
    vec_t  tbl[9];

    seq_gen #(.W(16), .NW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed_a(seed_a), .seed_b(seed_b),
        .n_terms(n_terms), .stop(stop), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_idx(out_idx), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // reference model: fills the scoreboard with the terms a run must emit
    function automatic void build(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b, input logic [7:0] n);
        longint prv = 0, cur = 0, s;
        q.delete();
        for (int k = 0; k < int'(n); k++) begin
            if (k == 0) cur = (m == 2'b01) ? 2 : (m == 2'b10) ? longint'(a) : 0;
            else if (k == 1) begin
                prv = cur;
                cur = (m == 2'b01) ? 1 : (m == 2'b10) ? longint'(b) : 1;
            end else begin
                s = cur + prv;
                prv = cur;
                if (s > 65535) begin
`ifdef SEQ_GEN_SAT_EN
                    cur = 65535;
`else
                    break;
`endif
                end else cur = s;
            end
            q.push_back('{cur[15:0], k[7:0]});
        end
    endfunction

    task automatic run_seq(input vec_t v, input int stall_at, input int stop_at);
        int cyc = 0, stalls = 0, exp_cyc;
        bit fin = 0;
        term_t t;
        build(v.m, v.a, v.b, v.n);
        @(negedge clk);
        mode = v.m; seed_a = v.a; seed_b = v.b; n_terms = v.n; start = 1; out_ready = 1;
        @(negedge clk);
        // scramble inputs: a correct DUT must not re-sample them mid-run
        start = 0; mode = 2'b01; seed_a = '1; seed_b = '1; n_terms = 8'd1;
        while (!fin && cyc < 300) begin
            cyc++;
            stop = 0; start = 0; out_ready = 1;
            if (done) fin = 1;
            else begin
                if (out_valid && stall_at >= 0 && int'(out_idx) == stall_at && stalls < 3) begin
                    out_ready = 0;
                    stalls++;
                    if (q.size() > 0) chk("stall_hold", {out_idx, out_data}, {q[0].i, q[0].d});
                end
                if (out_valid && int'(out_idx) == stop_at) stop = 1;
                if (out_valid && out_idx == 8'd2) start = 1;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) chk("extra_term", {out_valid, out_idx, out_data}, 0);
                    else begin
                        t = q.pop_front();
                        chk("term", {busy, out_idx, out_data}, {1'b1, t.i, t.d});
                    end
                    if (stop) q.delete();
                end
                @(negedge clk);
            end
        end
        stop = 0; start = 0;
        chk("done_seen", fin, 1);
        if (fin) begin
            exp_cyc = (v.n == 0) ? 1 : int'(v.idx) + 2 + ((stall_at >= 0) ? 3 : 0);
            chk("done_cycle", cyc, exp_cyc);
            chk("done_state", {out_valid, busy}, 0);
            chk("ovf", ovf, v.ovf);
            if (v.n != 0) chk("last_term", {out_idx, out_data}, {v.idx, v.last});
            chk("sb_empty", q.size(), 0);
            @(negedge clk);
            chk("done_pulse", {done, out_valid}, 0);
        end
    endtask

    initial begin
        int cyc;
        tbl[0] = '{2'd0, 16'd0, 16'd0, 8'd10, 16'd34, 8'd9, 1'b0};
        tbl[1] = '{2'd1, 16'd0, 16'd0, 8'd5, 16'd7, 8'd4, 1'b0};
        tbl[2] = '{2'd2, 16'd5, 16'd5, 8'd4, 16'd15, 8'd3, 1'b0};
        tbl[3] = '{2'd3, 16'd9, 16'd9, 8'd3, 16'd1, 8'd2, 1'b0};
        tbl[4] = '{2'd0, 16'd0, 16'd0, 8'd25, 16'd46368, 8'd24, 1'b0};
        tbl[5] = '{2'd0, 16'd0, 16'd0, 8'd1, 16'd0, 8'd0, 1'b0};
`ifdef SEQ_GEN_SAT_EN
        tbl[6] = '{2'd0, 16'd0, 16'd0, 8'd30, 16'd65535, 8'd29, 1'b1};
        tbl[7] = '{2'd2, 16'd65535, 16'd1, 8'd3, 16'd65535, 8'd2, 1'b1};
`else
        tbl[6] = '{2'd0, 16'd0, 16'd0, 8'd30, 16'd46368, 8'd24, 1'b1};
        tbl[7] = '{2'd2, 16'd65535, 16'd1, 8'd3, 16'd1, 8'd1, 1'b1};
`endif
        tbl[8] = '{2'd0, 16'd0, 16'd0, 8'd0, 16'd0, 8'd0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {out_valid, busy, done, ovf, out_idx, out_data}, 0);
        rst = 0;

        for (int i = 0; i < 9; i++) run_seq(tbl[i], -1, -1);

        run_seq(tbl[0], 3, -1);
        run_seq('{2'd0, 16'd0, 16'd0, 8'd10, 16'd3, 8'd4, 1'b0}, -1, 4);

        @(negedge clk);
        mode = 2'd0; n_terms = 8'd10; start = 1; out_ready = 1;
        @(negedge clk);
        start = 0;
        cyc = 0;
        while (!(out_valid && out_idx == 8'd6) && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        chk("rst_reach_idx6", {out_valid, out_idx, out_data}, {1'b1, 8'd6, 16'd8});
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_mid_run", {out_valid, busy, done, ovf, out_idx, out_data}, 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", {done, out_valid}, 0);
        end
        run_seq(tbl[0], -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Parametrised integer recurrence generator (term k = term k-1 + term k-2) with a run-length limit, overflow detection and a valid/ready output stream.
- Supports Fibonacci, Lucas and user-seeded modes.
- Sits as a stream source feeding downstream datapath/display logic; replaces the fixed 16-bit free-running Fibonacci counter.

Parameters:
- W, 16, data width of every term in bits.
- NW, 8, width of the term-count and term-index fields.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begins a run; sampled only in IDLE.
- mode  in  2  00 Fibonacci, 01 Lucas, 10 custom seeds, 11 reserved (behaves as 00).
- seed_a  in  W  term 0 in custom mode; sampled with start.
- seed_b  in  W  term 1 in custom mode; sampled with start.
- n_terms  in  NW  number of terms to emit; sampled with start.
- stop  in  1  abort request during RUN.
- out_ready  in  1  downstream accepts the current term.
- out_valid  out  1  out_data and out_idx are valid.
- out_data  out  W  current term.
- out_idx  out  NW  index k of the current term (0-based).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at end of run.
- ovf  out  1  set when the run ended on overflow; held until next start or rst.

Behaviour:
- Reset: rst, clk as decided. All outputs are 0 on reset and the FSM enters IDLE. rst overrides everything, including mid-run; the partial run is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start with n_terms>0.
  - Latch seeds: 00/11 -> a=0,b=1; 01 -> a=2,b=1; 10 -> seed_a,seed_b.
  - Clear ovf.
  - Next cycle: out_valid=1, out_data=a, out_idx=0. Latency start->first valid is 1 cycle.
- IDLE -> DONE on start with n_terms==0. No terms emitted; ovf=0.
- RUN: a term is accepted in a cycle where out_valid && out_ready.
  - While out_ready=0, out_data and out_idx hold stable.
  - On acceptance of term 0: next term is b.
  - On acceptance of term k≥1: next term is cur+prv, computed W+1 bits wide; prv<=cur.
  - out_idx increments by 1 per acceptance.
- End conditions, checked on acceptance:
  - out_idx==n_terms-1 -> DONE, ovf=0.
  - Carry out of next-term sum -> DONE, ovf=1. The accepted term is the last one; the wrapped value is never emitted.
  - If both conditions hold in the same cycle, the count limit wins and ovf=0.
- stop in RUN -> DONE next cycle, ovf unchanged.
  - stop has priority over a simultaneous acceptance: the term is treated as accepted, but no further terms are emitted.
- DONE: out_valid=0, busy=0, done=1 for exactly one cycle, then IDLE. out_data/out_idx keep the last values.
- start outside IDLE is ignored. Inputs are not re-sampled during a run.

Optional Feature:
- Macro: SEQ_GEN_SAT_EN.
- Defined: overflow does not end the run.
  - The overflowing term and all later terms emit as all-ones (2^W-1) until n_terms is reached.
  - ovf is set on the first saturated term and stays set through done.
- Undefined: overflow terminates the run as described in Behaviour.

Decomposition:
- Package seq_gen_pkg holds:
  - mode enum (MODE_FIB, MODE_LUC, MODE_CUST);
  - state enum (S_IDLE, S_RUN, S_DONE);
  - seed constants FIB_A=0, FIB_B=1, LUC_A=2, LUC_B=1.
- One sub-module: seq_gen_add, a W-bit adder with carry-out and optional saturation (SEQ_GEN_SAT_EN).

Test Plan:
- W=16, mode=00, n_terms=10, out_ready=1 -> out_data 0,1,1,2,3,5,8,13,21,34 on idx 0..9 in consecutive cycles; done pulse 1 cycle after idx 9; ovf=0.
- mode=01, n_terms=5 -> 2,1,3,4,7. mode=10, seed 5/5, n_terms=4 -> 5,5,10,15.
- mode=00, n_terms=30, SEQ_GEN_SAT_EN undefined -> last term 46368 at idx 24, then done with ovf=1. Defined -> idx 25..29 emit 65535, done after idx 29, ovf=1.
- out_ready low 3 cycles while idx=3 (value 2) -> out_data=2 and out_idx=3 stable; stream resumes with 3 at idx 4.
- stop at idx 4; and start with n_terms=0 -> done next cycle with no out_valid. start asserted during RUN -> ignored.
- rst asserted at idx 6 -> all outputs 0 next cycle, no done. A new start restarts at term 0.
